// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched scheduler and its arbiter.
package counter_sched_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter2.sv
// Two-way arbiter: round-robin when COUNTER_SCHED_RR_EN is defined,
// otherwise fixed priority with requester 0 winning ties.
module rr_arbiter2
  import counter_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       last,
  output logic [1:0] win
);

`ifdef COUNTER_SCHED_RR_EN
  logic ptr_r;

  // Pointer favours the requester that did not win the window just closed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= REQ_IDX0;
    end else if (adv) begin
      ptr_r <= ~last;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Favoured requester first, the other one otherwise.
  always_comb begin
    win = 2'b00;
    if ((ptr_r == REQ_IDX1) && req[1]) begin
      win = 2'b10;
    end else if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end else begin
      win = 2'b00;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clock, reset, adv, last};

  // Requester 0 always has priority.
  always_comb begin
    win = 2'b00;
    if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end else begin
      win = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter between two requesters by granting counting windows.
// Build option: COUNTER_SCHED_RR_EN selects round-robin arbitration.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] end0,
  input  logic [WIDTH-1:0] end1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] count_in
);

  state_t           state_r;
  state_t           state_s;
  logic             win_r;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] end_r;
  logic [1:0]       arb_win_s;
  logic             adv_s;
  logic             abort_s;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .adv   (adv_s),
    .last  (win_r),
    .win   (arb_win_s)
  );

  assign abort_s  = ~req[win_r];
  assign busy     = (state_r != ST_IDLE);
  assign cnt_data = start_r;

  // State register plus winner/start/end capture at grant time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      win_r   <= REQ_IDX0;
      start_r <= {WIDTH{1'b0}};
      end_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && (|req)) begin
        win_r   <= arb_win_s[1];
        start_r <= arb_win_s[1] ? start1 : start0;
        end_r   <= arb_win_s[1] ? end1 : end0;
      end else begin
        win_r   <= win_r;
        start_r <= start_r;
        end_r   <= end_r;
      end
    end
  end

  // Next state and counter controls; an abort also blocks LOAD so the counter holds.
  always_comb begin
    state_s    = state_r;
    gnt        = 2'b00;
    done       = 2'b00;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    adv_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        gnt = idx2onehot(win_r);
        if (abort_s) begin
          adv_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_s  = ST_RUN;
        end
      end
      ST_RUN: begin
        gnt = idx2onehot(win_r);
        if (abort_s) begin
          adv_s   = 1'b1;
          state_s = ST_IDLE;
        end else if (count_in == end_r) begin
          state_s = ST_DONE;
        end else begin
          cnt_enable = 1'b1;
          state_s    = ST_RUN;
        end
      end
      ST_DONE: begin
        gnt     = idx2onehot(win_r);
        done    = idx2onehot(win_r);
        adv_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched with a behavioural 8-bit counter.
module tb_counter_sched;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [7:0] start0, start1, end0, end1;
  logic [1:0] gnt, done;
  logic       busy, cnt_load, cnt_enable;
  logic [7:0] cnt_data;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] req;
    logic [7:0] s0, e0, s1, e1;
    int         w;
    int         k;
  } vec_t;
  vec_t vecs[5];

  counter_sched dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .start0     (start0),
    .start1     (start1),
    .end0       (end0),
    .end1       (end1),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_load   (cnt_load),
    .cnt_enable (cnt_enable),
    .cnt_data   (cnt_data),
    .count_in   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= 8'd0;
    else if (cnt_load) count <= cnt_data;
    else if (cnt_enable) count <= count + 8'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && done != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got %b expected none at %0t", done, $time);
      end else begin
        check("done_pulse", {30'd0, done}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_window(input logic [1:0] rq, input int w, input int k,
                            input logic [7:0] st, input logic [7:0] en, input int exp_wait);
    int waited = 0;
    int loads = 0;
    int ens = 0;
    int done_at = -1;
    logic [1:0] oh;
    oh = (w == 1) ? 2'b10 : 2'b01;
    req = rq;
    exp_q.push_back(oh);
    do begin
      @(negedge clock);
      waited++;
    end while (gnt == 2'b00 && waited < 6);
    check("grant_latency", waited, exp_wait);
    check("grant_onehot", {30'd0, gnt}, {30'd0, oh});
    check("busy_in_window", {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc <= k + 10; cyc++) begin
      if (cnt_load) begin
        loads++;
        check("load_data", {24'd0, cnt_data}, {24'd0, st});
      end
      if (cnt_enable) ens++;
      if (done != 2'b00) begin
        done_at = cyc;
        check("count_at_done", {24'd0, count}, {24'd0, en});
        break;
      end
      @(negedge clock);
    end
    check("done_cycle", done_at, k + 2);
    check("load_cycles", loads, 1);
    check("enable_cycles", ens, k);
  endtask

  initial begin
    int w;
    int waited;
    vecs[0] = '{req: 2'b01, s0: 8'd5,   e0: 8'd12, s1: 8'd0,   e1: 8'd0,   w: 0, k: 7};
    vecs[1] = '{req: 2'b10, s0: 8'd0,   e0: 8'd0,  s1: 8'd250, e1: 8'd3,   w: 1, k: 9};
    vecs[2] = '{req: 2'b01, s0: 8'd7,   e0: 8'd7,  s1: 8'd0,   e1: 8'd0,   w: 0, k: 0};
    vecs[3] = '{req: 2'b10, s0: 8'd0,   e0: 8'd0,  s1: 8'd0,   e1: 8'd255, w: 1, k: 255};
    vecs[4] = '{req: 2'b01, s0: 8'd255, e0: 8'd0,  s1: 8'd0,   e1: 8'd0,   w: 0, k: 1};

    reset = 1'b0; req = 2'b00;
    start0 = 8'd0; start1 = 8'd0; end0 = 8'd0; end1 = 8'd0;
    #1;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt_data", {24'd0, cnt_data}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      start0 = vecs[i].s0; end0 = vecs[i].e0;
      start1 = vecs[i].s1; end1 = vecs[i].e1;
      run_window(vecs[i].req, vecs[i].w, vecs[i].k,
                 vecs[i].w == 1 ? vecs[i].s1 : vecs[i].s0,
                 vecs[i].w == 1 ? vecs[i].e1 : vecs[i].e0, 1);
      req = 2'b00;
      repeat (2) @(negedge clock);
    end

    // Contention with both requests held.
    start0 = 8'd0; end0 = 8'd2; start1 = 8'd10; end1 = 8'd12;
    for (int i = 0; i < 4; i++) begin
`ifdef COUNTER_SCHED_RR_EN
      w = i % 2;
`else
      w = 0;
`endif
      run_window(2'b11, w, 2, (w == 1) ? 8'd10 : 8'd0, (w == 1) ? 8'd12 : 8'd2, (i == 0) ? 1 : 2);
    end
`ifdef COUNTER_SCHED_RR_EN
    run_window(2'b01, 0, 2, 8'd0, 8'd2, 2);
`else
    run_window(2'b10, 1, 2, 8'd10, 8'd12, 2);
`endif
    req = 2'b00;
    repeat (2) @(negedge clock);

    // Abort requester 0 at count 9, requester 1 pending.
    start0 = 8'd0; end0 = 8'd20; start1 = 8'd30; end1 = 8'd33;
    req = 2'b01;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(cnt_enable && count == 8'd9) && waited < 40);
    check("abort_reach9", {24'd0, count}, 32'd9);
    req = 2'b10;
    #1;
    check("abort_enable_low", {31'd0, cnt_enable}, 32'd0);
    @(negedge clock);
    check("abort_idle_gnt", {30'd0, gnt}, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    check("abort_count_hold", {24'd0, count}, 32'd9);
    run_window(2'b10, 1, 3, 8'd30, 8'd33, 1);
    req = 2'b00;
    repeat (2) @(negedge clock);

    // Asynchronous reset in the middle of a run.
    start0 = 8'd0; end0 = 8'd50;
    req = 2'b01;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (count != 8'd20 && waited < 40);
    check("rst_reach20", {24'd0, count}, 32'd20);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_gnt", {30'd0, gnt}, 32'd0);
    check("midrst_done", {30'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_load", {31'd0, cnt_load}, 32'd0);
    check("midrst_enable", {31'd0, cnt_enable}, 32'd0);
    check("midrst_data", {24'd0, cnt_data}, 32'd0);
    req = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    start0 = 8'd3; end0 = 8'd6;
    run_window(2'b01, 0, 3, 8'd3, 8'd6, 1);
    req = 2'b00;
    repeat (3) @(negedge clock);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
